// File: rtl/single_port_ram_arbiter_if.sv
// Request/response bundle between two requesters and the single-port RAM arbiter.
// Requester i owns bit i of the per-requester vectors and slice i of the packed buses.
interface single_port_ram_arbiter_if #(
    parameter int AW        = 10,
    parameter int RAM_WIDTH = 18
);
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0]             req_we;
    logic [2*AW-1:0]        req_addr;
    logic [2*RAM_WIDTH-1:0] req_wdata;
    logic [1:0]             rsp_valid;
    logic [RAM_WIDTH-1:0]   rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/single_port_ram_arbiter.sv
// Two-requester arbiter for one single-port RAM: burst-limited ownership, registered RAM command,
// in-order tag pipeline for responses. Define SP_RAM_ARB_WR_RSP_EN to make writes respond too.
module single_port_ram_arbiter #(
    parameter int RAM_WIDTH  = 18,
    parameter int RAM_DEPTH  = 1024,
    parameter int RD_LATENCY = 2,
    parameter int MAX_BURST  = 4,
    // Same value as clogb2(RAM_DEPTH-1): bits needed to address every entry.
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                     clka,
    input  logic                     rsta_n,
    single_port_ram_arbiter_if.slave bus,
    output logic [AW-1:0]            ram_addra,
    output logic [RAM_WIDTH-1:0]     ram_dina,
    output logic                     ram_wea,
    output logic                     ram_ena,
    output logic                     ram_regcea,
    output logic                     ram_rsta,
    input  logic [RAM_WIDTH-1:0]     ram_douta
);

    typedef enum logic {OWN0 = 1'b0, OWN1 = 1'b1} owner_t;

    typedef struct packed {
        logic valid;
        logic id;
`ifdef SP_RAM_ARB_WR_RSP_EN
        logic is_write;
`endif
    } tag_t;

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

    owner_t     owner;
    logic [3:0] burst_cnt;
    logic       own_id;
    logic       oth_id;
    logic       gnt_valid;
    logic       gnt_id;
    logic       accept;
    tag_t       tag_pipe [RD_LATENCY+1];
    tag_t       rsp_tag;

    assign own_id = (owner == OWN1);
    assign oth_id = ~own_id;

    // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = own_id;
        if (bus.req_valid[own_id] && ((burst_cnt < MAX_BURST_C) || !bus.req_valid[oth_id])) begin
            gnt_valid = 1'b1;
        end else if (bus.req_valid[oth_id]) begin
            gnt_valid = 1'b1;
            gnt_id    = oth_id;
        end
    end

    assign accept        = gnt_valid & rsta_n;
    assign bus.req_ready = accept ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            owner     <= OWN0;
            burst_cnt <= '0;
        end else if (!accept) begin
            burst_cnt <= '0;
        end else if (gnt_id == own_id) begin
            if (burst_cnt < MAX_BURST_C) begin
                burst_cnt <= burst_cnt + 4'd1;
            end
        end else begin
            // Zero-bubble handover: the new owner's first beat already counts.
            owner     <= owner_t'(gnt_id);
            burst_cnt <= 4'd1;
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            ram_ena   <= 1'b0;
            ram_wea   <= 1'b0;
            ram_addra <= '0;
            ram_dina  <= '0;
        end else begin
            ram_ena <= accept;
            ram_wea <= accept & bus.req_we[gnt_id];
            if (accept) begin
                ram_addra <= gnt_id ? bus.req_addr[AW +: AW] : bus.req_addr[0 +: AW];
                ram_dina  <= gnt_id ? bus.req_wdata[RAM_WIDTH +: RAM_WIDTH]
                                    : bus.req_wdata[0 +: RAM_WIDTH];
            end
        end
    end

    // NOTE: the tag pipeline is reset (the RAM array is not) so in-flight beats vanish on reset.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            for (int k = 0; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
`ifdef SP_RAM_ARB_WR_RSP_EN
            tag_pipe[0].valid    <= accept;
            tag_pipe[0].is_write <= bus.req_we[gnt_id];
`else
            tag_pipe[0].valid    <= accept & ~bus.req_we[gnt_id];
`endif
            tag_pipe[0].id       <= gnt_id;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // The last stage lines up with ram_douta for the beat it describes.
    assign rsp_tag       = tag_pipe[RD_LATENCY];
    assign bus.rsp_valid = {rsp_tag.valid & rsp_tag.id, rsp_tag.valid & ~rsp_tag.id};
    assign bus.rsp_data  = ram_douta;

    assign ram_regcea = 1'b1;
    assign ram_rsta   = ~rsta_n;

endmodule

// File: tb/tb_single_port_ram_arbiter.sv
// Bench for single_port_ram_arbiter: directed scenarios with literal checks plus a
// transaction-level model compared against the DUT every cycle.
module tb_single_port_ram_arbiter;
    localparam int W      = 18;
    localparam int DEPTH  = 1024;
    localparam int RD_LAT = 2;
    localparam int MAXB   = 4;
    localparam int AW     = 10;

    logic          clka = 1'b0;
    logic          rsta_n;
    logic [AW-1:0] ram_addra;
    logic [W-1:0]  ram_dina;
    logic [W-1:0]  ram_douta;
    logic          ram_wea;
    logic          ram_ena;
    logic          ram_regcea;
    logic          ram_rsta;

    int n_chk  = 0;
    int n_pass = 0;

    single_port_ram_arbiter_if #(.AW(AW), .RAM_WIDTH(W)) bus ();

    single_port_ram_arbiter #(
        .RAM_WIDTH (W),
        .RAM_DEPTH (DEPTH),
        .RD_LATENCY(RD_LAT),
        .MAX_BURST (MAXB)
    ) dut (
        .clka      (clka),
        .rsta_n    (rsta_n),
        .bus       (bus),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_ena   (ram_ena),
        .ram_regcea(ram_regcea),
        .ram_rsta  (ram_rsta),
        .ram_douta (ram_douta)
    );

    always #5 clka = ~clka;

    // Write-first RAM with an optional output register.
    logic [W-1:0] ram_mem [DEPTH];
    logic [W-1:0] ram_q1;
    logic [W-1:0] ram_q2;

    always @(posedge clka) begin
        if (ram_ena) begin
            if (ram_wea) begin
                ram_mem[ram_addra] <= ram_dina;
                ram_q1             <= ram_dina;
            end else begin
                ram_q1 <= ram_mem[ram_addra];
            end
        end
        if (ram_regcea) ram_q2 <= ram_q1;
    end

    assign ram_douta = (RD_LAT == 1) ? ram_q1 : ram_q2;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: grant rule, beat order, expected response per cycle slot.
    int           cyc = 0;
    int           m_owner;
    int           m_cnt;
    int           g;
    int           slot;
    int           rs;
    int           m_addr;
    logic         m_we;
    logic [W-1:0] m_din;
    logic [W-1:0] m_mem [int];
    logic [1:0]   pend_v [8];
    logic         pend_k [8];
    logic [W-1:0] pend_d [8];
    logic         prev_acc;
    logic         prev_we;
    int           prev_addr;
    logic [W-1:0] prev_din;

    always @(negedge clka) begin
        cyc++;
        slot = cyc % 8;
        if (!rsta_n) begin
            check("rst_ready", bus.req_ready, 2'b00);
            check("rst_rsp_valid", bus.rsp_valid, 2'b00);
            check("rst_ram_ena", ram_ena, 1'b0);
            check("rst_ram_wea", ram_wea, 1'b0);
            m_owner  = 0;
            m_cnt    = 0;
            prev_acc = 1'b0;
            for (int k = 0; k < 8; k++) pend_v[k] = 2'b00;
        end else begin
            g = -1;
            if (bus.req_valid[m_owner] && (m_cnt < MAXB || !bus.req_valid[1-m_owner])) g = m_owner;
            else if (bus.req_valid[1-m_owner]) g = 1 - m_owner;
            check("ready", bus.req_ready, (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01));

            check("ram_ena", ram_ena, prev_acc);
            check("ram_wea", ram_wea, prev_acc & prev_we);
            if (prev_acc) begin
                check("ram_addra", ram_addra, prev_addr);
                check("ram_dina", ram_dina, prev_din);
            end

            check("rsp_valid", bus.rsp_valid, pend_v[slot]);
            if (pend_v[slot] != 2'b00 && pend_k[slot]) check("rsp_data", bus.rsp_data, pend_d[slot]);
            pend_v[slot] = 2'b00;

            prev_acc = (g >= 0);
            if (g >= 0) begin
                m_we   = bus.req_we[g];
                m_addr = (g == 1) ? int'(bus.req_addr[AW +: AW]) : int'(bus.req_addr[0 +: AW]);
                m_din  = (g == 1) ? bus.req_wdata[W +: W] : bus.req_wdata[0 +: W];
                prev_we   = m_we;
                prev_addr = m_addr;
                prev_din  = m_din;
                rs = (cyc + RD_LAT + 1) % 8;
                if (m_we) begin
                    m_mem[m_addr] = m_din;
`ifdef SP_RAM_ARB_WR_RSP_EN
                    pend_v[rs] = (g == 1) ? 2'b10 : 2'b01;
                    pend_k[rs] = 1'b1;
                    pend_d[rs] = m_din;
`endif
                end else begin
                    pend_v[rs] = (g == 1) ? 2'b10 : 2'b01;
                    pend_k[rs] = m_mem.exists(m_addr);
                    if (pend_k[rs]) pend_d[rs] = m_mem[m_addr];
                end
                if (g == m_owner) m_cnt = (m_cnt < MAXB) ? m_cnt + 1 : MAXB;
                else begin
                    m_owner = g;
                    m_cnt   = 1;
                end
            end else begin
                m_cnt = 0;
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] we, input int a0, input int a1,
                         input int d0, input int d1);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_addr  = {AW'(a1), AW'(a0)};
        bus.req_wdata = {W'(d1), W'(d0)};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic pulse_reset();
        rsta_n = 1'b0;
        idle();
        step();
        rsta_n = 1'b1;
    endtask

    logic [1:0] tv  [10];
    logic [1:0] twe [10];

    initial begin
        tv  = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01, 2'b11, 2'b00};
        twe = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};

        // Reset holds everything quiet even with both requesters valid.
        rsta_n = 1'b0;
        drive(2'b11, 2'b00, 1, 2, 0, 0);
        step();
        step();
        @(negedge clka);
        check("rst_ready_held", bus.req_ready, 2'b00);
        check("rst_owner", dut.owner, 1'b0);
        check("rst_burst_cnt", dut.burst_cnt, 4'd0);
        check("rst_ram_addra", ram_addra, 0);
        check("rst_ram_dina", ram_dina, 0);
        check("rst_ram_rsta", ram_rsta, 1'b1);
        check("ram_regcea", ram_regcea, 1'b1);
        step();
        rsta_n = 1'b1;
        idle();
        step();

        // req0 writes 0x155 to addr 3, then reads it back.
        drive(2'b01, 2'b01, 3, 0, 'h155, 0);
        @(negedge clka);
        check("wr0_ready", bus.req_ready, 2'b01);
        step();
        drive(2'b01, 2'b00, 3, 0, 0, 0);
        @(negedge clka);
        check("rd0_ready", bus.req_ready, 2'b01);
        step();
        idle();
        @(negedge clka);
        check("rd0_ram_ena", ram_ena, 1'b1);
        check("rd0_ram_wea", ram_wea, 1'b0);
        check("rd0_ram_addra", ram_addra, 3);
        step();
        @(negedge clka);
        check("rd0_rsp_early", bus.rsp_valid, 2'b00);
        step();
        @(negedge clka);
        check("rd0_rsp_valid", bus.rsp_valid, 2'b01);
        check("rd0_rsp_data", bus.rsp_data, 'h155);
        step();

        // req1 write: responds only when write responses are enabled.
        drive(2'b10, 2'b10, 0, 5, 0, 'h2aa);
        @(negedge clka);
        check("wr1_ready", bus.req_ready, 2'b10);
        step();
        idle();
        step();
        step();
        @(negedge clka);
`ifdef SP_RAM_ARB_WR_RSP_EN
        check("wr1_rsp_valid", bus.rsp_valid, 2'b10);
        check("wr1_rsp_data", bus.rsp_data, 'h2aa);
`else
        check("wr1_no_rsp", bus.rsp_valid, 2'b00);
`endif
        step();

        // Both requesters continuously valid: bursts of MAXB, requester 0 first.
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            drive(2'b11, 2'b01, 16 + i, 3, 'h100 + i, 0);
            @(negedge clka);
            check("burst_seq", bus.req_ready, ((i % 8) < 4) ? 2'b01 : 2'b10);
            step();
        end
        idle();
        step();

        // Only req1: accepted every cycle, burst count saturates.
        for (int i = 0; i < 10; i++) begin
            drive(2'b10, 2'b00, 0, 16 + i, 0, 0);
            @(negedge clka);
            check("req1_only", bus.req_ready, 2'b10);
            step();
        end
        idle();
        @(negedge clka);
        check("sat_burst_cnt", dut.burst_cnt, 4'd4);
        check("sat_owner", dut.owner, 1'b1);
        step();

        // req0 stops after two beats while req1 waits: immediate handover.
        pulse_reset();
        drive(2'b11, 2'b00, 16, 17, 0, 0);
        @(negedge clka);
        check("handover_b0", bus.req_ready, 2'b01);
        step();
        @(negedge clka);
        check("handover_b1", bus.req_ready, 2'b01);
        step();
        drive(2'b10, 2'b00, 16, 17, 0, 0);
        @(negedge clka);
        check("handover_req1", bus.req_ready, 2'b10);
        step();
        idle();
        @(negedge clka);
        check("handover_owner", dut.owner, 1'b1);
        step();

        // Reset one cycle after a read accept discards the response.
        drive(2'b10, 2'b00, 0, 3, 0, 0);
        @(negedge clka);
        check("rst_rd_ready", bus.req_ready, 2'b10);
        step();
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clka);
            check("no_rsp_after_rst", bus.rsp_valid, 2'b00);
            step();
        end
        @(negedge clka);
        check("owner_after_rst", dut.owner, 1'b0);
        step();

        // Mixed traffic, checked by the model alone.
        for (int i = 0; i < 10; i++) begin
            drive(tv[i], twe[i], 40 + (i % 3), 40 + ((i + 1) % 3), 'h300 + i, 'h200 + i);
            step();
        end
        idle();
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule

// File: doc/single_port_ram_arbiter.md
SINGLE_PORT_RAM_ARBITER -- requirements
Module: single_port_ram_arbiter

Interface
REQ-001 The block SHALL have parameter RAM_WIDTH, default 18: data width in bits.
REQ-002 The block SHALL have parameter RAM_DEPTH, default 1024: entries; AW = clogb2(RAM_DEPTH-1).
REQ-003 The block SHALL have parameter RD_LATENCY, default 2: RAM read latency; 1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE.
REQ-004 The block SHALL have parameter MAX_BURST, default 4: maximum consecutive beats granted to one requester while the other waits; legal range 1..15.
REQ-005 The block SHALL have port clka, input, 1: the only clock; all logic samples on its rising edge.
REQ-006 The block SHALL have port rsta_n, input, 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, 2: request valid per requester i (bit i).
REQ-008 The block SHALL have port req_ready, output, 2: request accepted this cycle when req_valid[i] & req_ready[i].
REQ-009 The block SHALL have port req_we, input, 2: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, 2*AW: requester i uses slice [i*AW +: AW].
REQ-011 The block SHALL have port req_wdata, input, 2*RAM_WIDTH: requester i uses slice [i*RAM_WIDTH +: RAM_WIDTH].
REQ-012 The block SHALL have port rsp_valid, output, 2: one-cycle response strobe per requester; no backpressure.
REQ-013 The block SHALL have port rsp_data, output, RAM_WIDTH: response data, shared by both requesters.
REQ-014 The block SHALL have ports ram_addra (AW), ram_dina (RAM_WIDTH), ram_wea, ram_ena, ram_regcea and ram_rsta, outputs: they drive the RAM port.
REQ-015 The block SHALL have port ram_douta, input, RAM_WIDTH: RAM output data.

Function
REQ-016 Ownership SHALL be tracked in the registers owner (0/1) and burst_cnt (4 bits), with states OWN0 and OWN1.
REQ-017 Grant SHALL be combinational:
- to owner if req_valid[owner] and (burst_cnt < MAX_BURST or !req_valid[~owner]);
- else to ~owner if req_valid[~owner];
- else none.
REQ-018 req_ready SHALL be one-hot-or-zero: only the granted bit is high, and only while its req_valid is high; req_ready SHALL never depend on req_we or req_addr.
REQ-019 On an accepted beat by the owner, burst_cnt SHALL increment, saturating at MAX_BURST.
REQ-020 On an accepted beat by ~owner, owner SHALL toggle and burst_cnt SHALL become 1 in the same edge (zero-bubble switch).
REQ-021 In a cycle with no accepted beat, burst_cnt SHALL clear to 0 and owner SHALL hold.
REQ-022 An accepted beat SHALL be registered onto the RAM port in the next cycle: ram_ena=1, ram_wea=req_we[i], ram_addra and ram_dina from slice i; otherwise ram_ena=0 and ram_wea=0.
REQ-023 ram_regcea SHALL be constant 1, and ram_rsta SHALL equal ~rsta_n.
REQ-024 A tag pipeline of depth RD_LATENCY+1 SHALL carry {valid, requester id, is_write} per beat.
REQ-025 rsp_valid[i] SHALL pulse exactly RD_LATENCY+1 cycles after the accept cycle of a read by requester i.
REQ-026 rsp_data SHALL be ram_douta passed through combinationally.
REQ-027 Throughput SHALL be one beat per cycle sustained; responses SHALL return in accept order.
REQ-028 When both requesters assert continuously, grants SHALL alternate in bursts of exactly MAX_BURST beats.

Reset
REQ-029 While rsta_n=0, all state SHALL clear asynchronously: owner=0, burst_cnt=0, tag pipeline empty, ram_ena=0, ram_wea=0, ram_addra=0, ram_dina=0, rsp_valid=0.
REQ-030 req_ready SHALL be 0 while rsta_n=0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight tags; no rsp_valid SHALL follow deassertion for beats accepted before reset.
REQ-032 Reset SHALL not alter RAM contents.
REQ-033 After deassertion, requester 0 SHALL win the first simultaneous request.

Configuration
REQ-034 Macro SP_RAM_ARB_WR_RSP_EN, when defined, SHALL make writes also produce rsp_valid[i] at RD_LATENCY+1 cycles, with rsp_data equal to the written data (write-first).
REQ-035 When SP_RAM_ARB_WR_RSP_EN is undefined, writes SHALL produce no response, and the tag pipeline SHALL omit the is_write field.

Verification
REQ-036 Scenario: reset; req0 writes 0x155 to addr 3, then reads addr 3; RD_LATENCY=2 -> rsp_valid[0] pulses 3 cycles after the read accept with rsp_data=0x155; rsp_valid[1] stays 0.
REQ-037 Scenario: both requesters valid continuously for 16 cycles, MAX_BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,0,... with no idle cycle.
REQ-038 Scenario: only req1 valid for 10 cycles -> req1 accepted every cycle, and burst_cnt saturates at 4.
REQ-039 Scenario: rsta_n pulsed low one cycle after a read accept -> no rsp_valid afterwards, and owner=0.
REQ-040 Scenario: SP_RAM_ARB_WR_RSP_EN defined, req1 writes 0x2AA, RD_LATENCY=1 -> rsp_valid[1] 2 cycles after accept with rsp_data=0x2AA; without the macro, no pulse.
REQ-041 Scenario: req0 deasserts after 2 beats while req1 is pending -> req1 is granted in the next cycle, and owner becomes 1.
